// File: rtl/mealy_1011_pkg.sv
// mealy_1011_pkg: state type and target pattern shared by the 1011 detector and its bench
package mealy_1011_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_1    = 2'b01,
    S_10   = 2'b10,
    S_101  = 2'b11
  } state_e;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/mealy_1011_sequence_detector.sv
// mealy_1011_sequence_detector: Mealy FSM flagging 1-0-1-1 on a serial bit stream, zero-latency match flag
module mealy_1011_sequence_detector
  import mealy_1011_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic f
);
  state_e r_state;
  state_e w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  // f is gated by rst so it stays low while reset holds, even as state clears
  always_comb begin
    w_next = S_IDLE;
    f      = 1'b0;
    case (r_state)
      S_IDLE: w_next = i ? S_1 : S_IDLE;
      S_1:    w_next = i ? S_1 : S_10;
      S_10:   w_next = i ? S_101 : S_IDLE;
      S_101: begin
        w_next = i ? (OVERLAP ? S_1 : S_IDLE) : S_10;
        f      = rst & i;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mealy_1011_sequence_detector.sv
// tb_mealy_1011_sequence_detector: scoreboard bench checking overlapping and non-overlapping detectors against a history-queue model
module tb_mealy_1011_sequence_detector;
  import mealy_1011_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i   = 1'b0;
  logic f_ov, f_no;

  mealy_1011_sequence_detector #(.OVERLAP(1'b1)) u_ov (.clk(clk), .rst(rst), .i(i), .f(f_ov));
  mealy_1011_sequence_detector #(.OVERLAP(1'b0)) u_no (.clk(clk), .rst(rst), .i(i), .f(f_no));

  always #5 clk = ~clk;

  typedef struct {
    bit e_ov;
    bit e_no;
    int cyc;
  } exp_t;

  exp_t sb[$];
  bit   h_ov[$];
  bit   h_no[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  // A match is simply "the last four bits seen since the last restart spell the pattern"
  function automatic bit ends_with_pattern(bit q[$]);
    logic [3:0] tail;
    if (q.size() < 4) return 1'b0;
    tail = {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]};
    return tail == PATTERN;
  endfunction

  task automatic step(input bit rv, input bit iv);
    exp_t e;
    @(negedge clk);
    rst = rv;
    i   = iv;
    cyc++;
    e.cyc = cyc;
    if (!rv) begin
      h_ov.delete();
      h_no.delete();
      e.e_ov = 1'b0;
      e.e_no = 1'b0;
    end else begin
      h_ov.push_back(iv);
      h_no.push_back(iv);
      e.e_ov = ends_with_pattern(h_ov);
      e.e_no = ends_with_pattern(h_no);
      if (e.e_no) h_no.delete();
      while (h_ov.size() > 4) void'(h_ov.pop_front());
      while (h_no.size() > 4) void'(h_no.pop_front());
    end
    sb.push_back(e);
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n);
    step(1'b0, 1'b0);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k]);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b0;
    i = 1'b1;
    #2 rst = 1'b1;
    h_ov.delete();
    h_no.delete();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (f_ov === e.e_ov) passed++;
        else $display("FAIL f_ovl cyc=%0d: got %0b expected %0b", e.cyc, f_ov, e.e_ov);
        total++;
        if (f_no === e.e_no) passed++;
        else $display("FAIL f_novl cyc=%0d: got %0b expected %0b", e.cyc, f_no, e.e_no);
      end
    end
  end

  initial begin : driver
    for (int k = 0; k < 3; k++) step(1'b0, k[0]);
    run_seq(16'b01011, 5);
    run_seq(16'b01011011, 8);
    run_seq(16'b101011, 6);
    run_seq(16'b111001011, 9);
    run_seq(16'b101, 3);
    reset_pulse();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 63) != 0, $urandom_range(0, 99) < 60);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
